instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of the decode and immediate-generation logic. It owns the PC and issues one instruction-memory request at a time. It holds the returned word in `currInstr`/`currPC` with a valid/ready handshake to decode. It accepts PC redirects from the branch/jump path, computed as PC + generated immediate, and flags misaligned targets and memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- TIMEOUT, 64, max cycles in WAIT before timeout fault; range 2..255.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- imemReq  out  1  request valid to instruction memory
- imemAddr  out  32  request address (= pc)
- imemGnt  in  1  memory accepts request this cycle (imemReq & imemGnt = issue)
- imemValid  in  1  response data valid (single-cycle pulse)
- imemRdata  in  32  response instruction word
- instrReady  in  1  decode consumes held instruction
- redirectEn  in  1  load redirectTarget into pc (taken branch/JAL/JALR)
- redirectTarget  in  32  new PC
- currInstr  out  32  held instruction to decode/immediate logic
- currPC  out  32  address of currInstr
- instrValid  out  1  currInstr/currPC valid
- fetchFault  out  1  sticky fault indicator
- faultCause  out  2  01 = misaligned redirect, 10 = memory timeout, 00 = none

Behaviour:
- Reset (async, immediate):
  - state = BOOT, pc = RESET_PC.
  - currInstr = 32'h0000_0013 (NOP), currPC = RESET_PC.
  - instrValid = 0, imemReq = 0, fetchFault = 0, faultCause = 00.
  - Internal drop flag and timeout counter = 0.
- States: BOOT, FETCH, WAIT, HOLD, FAULT.
- BOOT: next cycle goes to FETCH unconditionally. This gives one idle cycle after reset release.
- FETCH:
  - imemReq = 1, imemAddr = pc.
  - On imemGnt, go to WAIT and clear the counter.
  - imemReq stays high with a stable address until granted.
- WAIT:
  - imemReq = 0; counter increments each cycle.
  - On imemValid with drop clear: currInstr <= imemRdata, currPC <= pc, go to HOLD. instrValid = 1 from the next cycle.
  - On imemValid with drop set: discard the data, clear drop, go to FETCH.
  - If the counter reaches TIMEOUT-1 without imemValid: go to FAULT with cause 10.
- HOLD:
  - instrValid = 1; currInstr/currPC stable.
  - On instrReady: pc <= pc + 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0), instrValid <= 0, go to FETCH.
  - Fetch latency is at least 3 cycles per instruction: FETCH, WAIT, HOLD.
- Redirect (redirectEn = 1, any state except BOOT/FAULT); has priority over instrReady and pc + 4:
  - If redirectTarget[1:0] != 00: go to FAULT with cause 01; pc is unchanged.
  - Otherwise: pc <= redirectTarget and instrValid <= 0 next cycle.
    - From FETCH: the new address is presented next cycle. A grant coinciding with the redirect is treated as issued, so set drop and go to WAIT.
    - From WAIT: set drop, stay in WAIT. If imemValid arrives in the same cycle, discard it and go to FETCH with drop clear.
    - From HOLD: go to FETCH.
- redirectEn during BOOT is ignored.
- FAULT: absorbing until reset.
  - fetchFault = 1, faultCause held, imemReq = 0, instrValid = 0.
  - currPC holds the last valid value.
  - A pending response is ignored.
- Only one outstanding memory request at a time.
- imemValid outside WAIT is ignored.
- The async reset in mid-transaction abandons the request; the memory side must tolerate the lost response.

Test Plan:
- Reset release, memory grants same cycle, imemValid 1 cycle later with 32'h00500093, instrReady held 1 -> imemAddr 0, 4, 8 in sequence; currInstr = 32'h00500093 with currPC = 0; first instrValid 3 cycles after BOOT.
- HOLD with instrReady = 0 for 5 cycles -> currInstr/currPC stable, no imemReq; then instrReady -> next imemAddr = currPC + 4.
- In WAIT, redirectEn with target 32'h0000_0100, then imemValid with 32'hDEADBEEF -> word discarded, instrValid never rises for it; next imemAddr = 32'h100.
- Redirect in HOLD coincident with instrReady, target 32'h0000_0040 -> pc = 32'h40, not pc + 4; instrValid low next cycle.
- Redirect target 32'h0000_0102 -> fetchFault = 1, faultCause = 01, imemReq stays 0 until reset.
- Memory grants but never returns imemValid, TIMEOUT = 8 -> fault after 8 WAIT cycles, faultCause = 10; reset clears the fault and refetches RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory request at a
// time, holds the returned word for decode behind a valid/ready handshake, and
// accepts PC redirects from the branch/jump path. Misaligned redirect targets and
// memory responses that never arrive put the unit into a sticky fault state.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,

    // Instruction memory request/response
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,

    // Decode handshake
    input  logic        instrReady,

    // Branch/jump redirect
    input  logic        redirectEn,
    input  logic [31:0] redirectTarget,

    // Held instruction
    output logic [31:0] currInstr,
    output logic [31:0] currPC,
    output logic        instrValid,

    // Fault reporting
    output logic        fetchFault,
    output logic [1:0]  faultCause
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    // Counter value reached on the last WAIT cycle allowed before a timeout
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    localparam logic [1:0] CauseNone      = 2'b00;
    localparam logic [1:0] CauseMisalign  = 2'b01;
    localparam logic [1:0] CauseTimeout   = 2'b10;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StWait,
        StHold,
        StFault
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_drop;        // outstanding response belongs to a stale PC
    logic        r_fault;
    logic [1:0]  r_cause;
    logic [7:0]  r_cnt;         // WAIT cycles elapsed minus one

    // ------------------------------------------------------------------------
    // Decoded conditions
    // ------------------------------------------------------------------------

    logic        w_redirect_live;
    logic        w_redirect_bad;
    logic        w_redirect_ok;
    logic        w_timeout;
    logic [31:0] w_pc_seq;

    // Redirects only count once the unit is running and not faulted
    assign w_redirect_live = redirectEn &&
                             ((r_state == StFetch) ||
                              (r_state == StWait)  ||
                              (r_state == StHold));
    assign w_redirect_bad  = w_redirect_live && (redirectTarget[1:0] != 2'b00);
    assign w_redirect_ok   = w_redirect_live && (redirectTarget[1:0] == 2'b00);

    // >= keeps the timeout reachable even if the counter ever passes the limit
    assign w_timeout       = (r_cnt >= CntLast);

    // Sequential next PC; 32-bit add wraps naturally at the top of memory
    assign w_pc_seq        = r_pc + 32'd4;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Request is raised for the whole FETCH state with the PC as a stable address
    assign imemReq    = (r_state == StFetch);
    assign imemAddr   = r_pc;

    assign currInstr  = r_instr;
    assign currPC     = r_instr_pc;
    assign instrValid = r_instr_valid;
    assign fetchFault = r_fault;
    assign faultCause = r_cause;

    // ------------------------------------------------------------------------
    // Fetch FSM with its registered outputs and datapath
    // ------------------------------------------------------------------------

    // Single sequential process: state, PC, held instruction and fault flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StBoot;
            r_pc          <= RESET_PC;
            r_instr       <= NopInstr;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_drop        <= 1'b0;
            r_fault       <= 1'b0;
            r_cause       <= CauseNone;
            r_cnt         <= 8'd0;
        end else begin
            unique case (r_state)
                // One idle cycle after reset release; redirects are ignored here
                StBoot: begin
                    r_state <= StFetch;
                end

                StFetch: begin
                    if (w_redirect_bad) begin
                        r_state       <= StFault;
                        r_fault       <= 1'b1;
                        r_cause       <= CauseMisalign;
                        r_instr_valid <= 1'b0;
                    end else if (w_redirect_ok) begin
                        r_pc <= redirectTarget;
                        // A grant in the same cycle already issued the old address,
                        // so its response must be thrown away
                        if (imemGnt) begin
                            r_state <= StWait;
                            r_drop  <= 1'b1;
                            r_cnt   <= 8'd0;
                        end
                    end else if (imemGnt) begin
                        r_state <= StWait;
                        r_cnt   <= 8'd0;
                    end
                end

                StWait: begin
                    if (w_redirect_bad) begin
                        r_state       <= StFault;
                        r_fault       <= 1'b1;
                        r_cause       <= CauseMisalign;
                        r_instr_valid <= 1'b0;
                    end else if (imemValid) begin
                        if (w_redirect_ok) begin
                            // Response is for the old path; go fetch the target
                            r_pc    <= redirectTarget;
                            r_drop  <= 1'b0;
                            r_state <= StFetch;
                        end else if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= StFetch;
                        end else begin
                            r_instr       <= imemRdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= StHold;
                        end
                    end else begin
                        // Keep waiting for the in-flight response, but mark it stale
                        if (w_redirect_ok) begin
                            r_pc   <= redirectTarget;
                            r_drop <= 1'b1;
                        end
                        if (w_timeout) begin
                            r_state       <= StFault;
                            r_fault       <= 1'b1;
                            r_cause       <= CauseTimeout;
                            r_instr_valid <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end

                StHold: begin
                    if (w_redirect_bad) begin
                        r_state       <= StFault;
                        r_fault       <= 1'b1;
                        r_cause       <= CauseMisalign;
                        r_instr_valid <= 1'b0;
                    end else if (w_redirect_ok) begin
                        // Redirect wins over a coincident consume
                        r_pc          <= redirectTarget;
                        r_instr_valid <= 1'b0;
                        r_state       <= StFetch;
                    end else if (instrReady) begin
                        r_pc          <= w_pc_seq;
                        r_instr_valid <= 1'b0;
                        r_state       <= StFetch;
                    end
                end

                // Absorbing until reset; late responses and redirects are ignored
                StFault: begin
                    r_instr_valid <= 1'b0;
                end

                default: begin
                    r_state <= StFault;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with a simple
// memory responder, a transaction-level model compared every cycle, and
// hand-computed literal checks at the key points of each scenario.

module tb_instr_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam int          Timeout = 8;

    logic        clk;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic        instrReady;
    logic        redirectEn;
    logic [31:0] redirectTarget;
    logic [31:0] currInstr;
    logic [31:0] currPC;
    logic        instrValid;
    logic        fetchFault;
    logic [1:0]  faultCause;

    instr_fetch_unit #(
        .RESET_PC (ResetPc),
        .TIMEOUT  (Timeout)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemGnt        (imemGnt),
        .imemValid      (imemValid),
        .imemRdata      (imemRdata),
        .instrReady     (instrReady),
        .redirectEn     (redirectEn),
        .redirectTarget (redirectTarget),
        .currInstr      (currInstr),
        .currPC         (currPC),
        .instrValid     (instrValid),
        .fetchFault     (fetchFault),
        .faultCause     (faultCause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Memory responder knobs
    int          resp_left = -1;
    int          resp_lat  = 0;
    bit          no_resp   = 1'b0;
    logic [31:0] resp_word = 32'h0;

    // Transaction-level model
    bit          m_boot, m_req, m_out, m_stale, m_hold, m_fault;
    int          m_waited;
    logic [1:0]  m_cause;
    logic [31:0] m_pc, m_instr, m_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_req    = 1'b0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_hold   = 1'b0;
        m_fault  = 1'b0;
        m_waited = 0;
        m_cause  = 2'b00;
        m_pc     = ResetPc;
        m_instr  = 32'h0000_0013;
        m_ipc    = ResetPc;
    endtask

    // Advance the model by one clock using the inputs the DUT sees at the edge
    task automatic model_step();
        bit live, bad;
        live = redirectEn && !m_boot && !m_fault;
        bad  = live && (redirectTarget[1:0] != 2'b00);
        if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
        end else if (m_fault) begin
            m_hold = 1'b0;
        end else if (bad) begin
            m_fault = 1'b1;
            m_cause = 2'b01;
            m_req   = 1'b0;
            m_out   = 1'b0;
            m_hold  = 1'b0;
        end else if (m_req) begin
            if (live) m_pc = redirectTarget;
            if (imemGnt) begin
                m_req    = 1'b0;
                m_out    = 1'b1;
                m_waited = 0;
                m_stale  = live;
            end
        end else if (m_out) begin
            m_waited++;
            if (imemValid) begin
                m_out = 1'b0;
                if (live) begin
                    m_pc    = redirectTarget;
                    m_stale = 1'b0;
                    m_req   = 1'b1;
                end else if (m_stale) begin
                    m_stale = 1'b0;
                    m_req   = 1'b1;
                end else begin
                    m_instr = imemRdata;
                    m_ipc   = m_pc;
                    m_hold  = 1'b1;
                end
            end else begin
                if (live) begin
                    m_pc    = redirectTarget;
                    m_stale = 1'b1;
                end
                if (m_waited >= Timeout) begin
                    m_fault = 1'b1;
                    m_cause = 2'b10;
                    m_out   = 1'b0;
                end
            end
        end else if (m_hold) begin
            if (live) begin
                m_pc   = redirectTarget;
                m_hold = 1'b0;
                m_req  = 1'b1;
            end else if (instrReady) begin
                m_pc   = m_pc + 32'd4;
                m_hold = 1'b0;
                m_req  = 1'b1;
            end
        end
    endtask

    // One clock: model steps at the edge, inputs and responder update 2ns later
    task automatic tick();
        logic issue;
        issue = imemReq && imemGnt;
        @(posedge clk);
        if (!reset) model_step();
        #2;
        imemValid = 1'b0;
        if (issue && !no_resp) resp_left = resp_lat;
        if (resp_left == 0) begin
            imemValid = 1'b1;
            imemRdata = resp_word;
            resp_left = -1;
        end else if (resp_left > 0) begin
            resp_left--;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        #1;
        model_reset();
        resp_left = -1;
        imemValid = 1'b0;
        tick();
        cmp_en    = 1'b1;
        tick();
        chk("rst_req",   {31'b0, imemReq},    32'd0);
        chk("rst_valid", {31'b0, instrValid}, 32'd0);
        chk("rst_instr", currInstr,           32'h0000_0013);
        chk("rst_pc",    currPC,              ResetPc);
        chk("rst_fault", {31'b0, fetchFault}, 32'd0);
        chk("rst_cause", {30'b0, faultCause}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirectEn     = 1'b1;
        redirectTarget = target;
        tick();
        redirectEn     = 1'b0;
    endtask

    // Compare every cycle against the model, away from the active edge
    initial begin
        wait (cmp_en);
        forever begin
            @(negedge clk);
            chk("cmp_imemReq",    {31'b0, imemReq},    {31'b0, m_req});
            chk("cmp_imemAddr",   imemAddr,            m_pc);
            chk("cmp_instrValid", {31'b0, instrValid}, {31'b0, m_hold});
            chk("cmp_currInstr",  currInstr,           m_instr);
            chk("cmp_currPC",     currPC,              m_ipc);
            chk("cmp_fetchFault", {31'b0, fetchFault}, {31'b0, m_fault});
            chk("cmp_faultCause", {30'b0, faultCause}, {30'b0, m_cause});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got hang, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        imemGnt        = 1'b1;
        imemValid      = 1'b0;
        imemRdata      = 32'h0;
        instrReady     = 1'b1;
        redirectEn     = 1'b0;
        redirectTarget = 32'h0;
        resp_word      = 32'h0050_0093;
        model_reset();
        @(posedge clk);
        #2;

        // Back-to-back sequential fetch
        do_reset();
        tick();
        chk("s1_req0",  {31'b0, imemReq}, 32'd1);
        chk("s1_addr0", imemAddr,         32'h0);
        tick();
        chk("s1_wait_valid", {31'b0, instrValid}, 32'd0);
        tick();
        chk("s1_first_valid", {31'b0, instrValid}, 32'd1);
        chk("s1_instr",       currInstr,           32'h0050_0093);
        chk("s1_pc",          currPC,              32'h0);
        tick();
        chk("s1_addr4", imemAddr,         32'h4);
        chk("s1_req4",  {31'b0, imemReq}, 32'd1);
        repeat (3) tick();
        chk("s1_addr8", imemAddr, 32'h8);

        // Stall in HOLD
        instrReady = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2_hold_valid", {31'b0, instrValid}, 32'd1);
            chk("s2_hold_pc",    currPC,              32'h8);
            chk("s2_hold_noreq", {31'b0, imemReq},    32'd0);
        end
        instrReady = 1'b1;
        tick();
        chk("s2_next_addr", imemAddr, 32'hC);
        instrReady = 1'b0;

        // Redirect while waiting: stale word discarded
        resp_lat  = 1;
        resp_word = 32'hDEAD_BEEF;
        tick();
        redirect(32'h0000_0100);
        chk("s3_pc_redir", imemAddr,            32'h100);
        chk("s3_novalid",  {31'b0, instrValid}, 32'd0);
        tick();
        chk("s3_refetch_req",  {31'b0, imemReq},    32'd1);
        chk("s3_refetch_addr", imemAddr,            32'h100);
        chk("s3_dropped",      currInstr,           32'h0050_0093);
        chk("s3_drop_novalid", {31'b0, instrValid}, 32'd0);
        resp_lat  = 0;
        resp_word = 32'h00A0_0113;
        repeat (2) tick();
        chk("s3_new_pc",    currPC,    32'h100);
        chk("s3_new_instr", currInstr, 32'h00A0_0113);

        // Redirect in HOLD beats a coincident consume
        instrReady = 1'b1;
        redirect(32'h0000_0040);
        chk("s4_valid_low", {31'b0, instrValid}, 32'd0);
        chk("s4_addr",      imemAddr,            32'h40);
        repeat (2) tick();
        chk("s4_pc", currPC, 32'h40);
        tick();
        // Ungranted request holds address, then redirect coincides with grant
        imemGnt    = 1'b0;
        instrReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s4_stall_req",  {31'b0, imemReq}, 32'd1);
            chk("s4_stall_addr", imemAddr,         32'h44);
        end
        imemGnt = 1'b1;
        redirect(32'h0000_0200);
        chk("s4_gnt_redir_addr", imemAddr,         32'h200);
        chk("s4_gnt_redir_req",  {31'b0, imemReq}, 32'd0);
        tick();
        chk("s4_refetch_addr", imemAddr,            32'h200);
        chk("s4_refetch_val",  {31'b0, instrValid}, 32'd0);
        repeat (2) tick();
        chk("s4_pc200", currPC, 32'h200);
        // PC wrap at the top of memory
        redirect(32'hFFFF_FFFC);
        repeat (2) tick();
        chk("s4_pc_top", currPC, 32'hFFFF_FFFC);
        instrReady = 1'b1;
        tick();
        chk("s4_wrap_addr", imemAddr, 32'h0);
        instrReady = 1'b0;
        repeat (2) tick();

        // Misaligned redirect faults
        redirect(32'h0000_0102);
        chk("s5_fault", {31'b0, fetchFault}, 32'd1);
        chk("s5_cause", {30'b0, faultCause}, 32'd1);
        chk("s5_noval", {31'b0, instrValid}, 32'd0);
        chk("s5_curpc", currPC,              32'h0);
        instrReady     = 1'b1;
        redirectEn     = 1'b1;
        redirectTarget = 32'h0000_0300;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s5_sticky_req",   {31'b0, imemReq},    32'd0);
            chk("s5_sticky_cause", {30'b0, faultCause}, 32'd1);
        end
        redirectEn = 1'b0;

        // Memory timeout, then reset recovery
        no_resp = 1'b1;
        do_reset();
        repeat (9) tick();
        chk("s6_pre_fault", {31'b0, fetchFault}, 32'd0);
        chk("s6_waiting",   {31'b0, imemReq},    32'd0);
        tick();
        chk("s6_fault", {31'b0, fetchFault}, 32'd1);
        chk("s6_cause", {30'b0, faultCause}, 32'd2);
        repeat (3) tick();
        chk("s6_sticky", {31'b0, fetchFault}, 32'd1);
        no_resp = 1'b0;
        do_reset();
        tick();
        chk("s6_refetch_req",  {31'b0, imemReq}, 32'd1);
        chk("s6_refetch_addr", imemAddr,         ResetPc);
        repeat (2) tick();
        chk("s6_recovered_valid", {31'b0, instrValid}, 32'd1);
        chk("s6_recovered_pc",    currPC,              ResetPc);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
